// File: rtl/kl_pipe_pkg.sv
// Shared pipeline types: branch condition codes, memory-stage states and the flag register.
// With MEMSTAGE_CARRY_FLAG_EN defined, the flags gain a carry bit and conditions widen to 4 bits.
package kl_pipe_pkg;

`ifdef MEMSTAGE_CARRY_FLAG_EN
  localparam int unsigned COND_W = 4;

  typedef enum logic [COND_W-1:0] {
    COND_NV = 4'd0,
    COND_AL = 4'd1,
    COND_EQ = 4'd2,
    COND_NE = 4'd3,
    COND_LT = 4'd4,
    COND_LE = 4'd5,
    COND_GT = 4'd6,
    COND_GE = 4'd7,
    COND_HS = 4'd8,
    COND_LO = 4'd9
  } cond_e;

  typedef struct packed {
    logic n;
    logic z;
    logic v;
    logic c;
  } flags_t;
`else
  localparam int unsigned COND_W = 3;

  typedef enum logic [COND_W-1:0] {
    COND_NV = 3'd0,
    COND_AL = 3'd1,
    COND_EQ = 3'd2,
    COND_NE = 3'd3,
    COND_LT = 3'd4,
    COND_LE = 3'd5,
    COND_GT = 3'd6,
    COND_GE = 3'd7
  } cond_e;

  typedef struct packed {
    logic n;
    logic z;
    logic v;
  } flags_t;
`endif

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    MEM   = 2'd1,
    FULL  = 2'd2
  } memst_state_e;

  // Overflow from operand signs and result sign: (a,b,n) in {011,100}.
  function automatic logic calc_v(input logic a, input logic b, input logic n);
    return (~a & b & n) | (a & ~b & ~n);
  endfunction

endpackage

// File: rtl/kl_cond_eval.sv
// Branch condition evaluator: flag register x condition code -> take. Shared with fetch.
module kl_cond_eval
  import kl_pipe_pkg::*;
(
  input  flags_t            flags,
  input  logic [COND_W-1:0] cond,
  output logic              take_c
);

  logic lt;

  // Decode the condition against the current flags; unused codes never take.
  always_comb begin
    lt     = flags.n ^ flags.v;
    take_c = 1'b0;
    case (cond_e'(cond))
      COND_NV: take_c = 1'b0;
      COND_AL: take_c = 1'b1;
      COND_EQ: take_c = flags.z;
      COND_NE: take_c = ~flags.z;
      COND_LT: take_c = lt;
      COND_LE: take_c = lt | flags.z;
      COND_GT: take_c = ~(lt | flags.z);
      COND_GE: take_c = ~lt;
`ifdef MEMSTAGE_CARRY_FLAG_EN
      COND_HS: take_c = flags.c;
      COND_LO: take_c = ~flags.c;
`endif
      default: take_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/pipeline_mem_stage.sv
// Memory-access / flag stage between execute and writeback.
// Registers the op, runs loads/stores over a wait-state memory port, keeps N/Z/V flags and
// resolves the delayed branch. MEMSTAGE_CARRY_FLAG_EN adds carry_in/flag_c and HS/LO conditions.
module pipeline_mem_stage
  import kl_pipe_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned CTRL_W = 22
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic              is_load,
  input  logic              is_store,
  input  logic              set_flags,
  input  logic [DATA_W-1:0] result_in,
  input  logic [DATA_W-1:0] store_data_in,
  input  logic              sign_a_in,
  input  logic              sign_b_in,
  input  logic [DATA_W-1:0] br_target_in,
  input  logic [COND_W-1:0] br_cond_in,
`ifdef MEMSTAGE_CARRY_FLAG_EN
  input  logic              carry_in,
  output logic              flag_c,
`endif
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic [DATA_W-1:0] result_out,
  output logic              flag_n,
  output logic              flag_z,
  output logic              flag_v,
  output logic              br_take,
  output logic [DATA_W-1:0] br_target_out
);

  memst_state_e      state_q;
  flags_t            flags_q;
  flags_t            flags_d;
  logic [COND_W-1:0] br_cond_q;
  logic              capture;

  // Accept a new op when empty, or when the held op leaves this same cycle.
  assign in_ready = ~rst & ((state_q == EMPTY) | ((state_q == FULL) & out_ready));
  assign capture  = in_valid & in_ready;

  // Next flag value from the ALU result (never from load data).
  always_comb begin
    flags_d = flags_q;
    if (set_flags) begin
      flags_d.n = result_in[DATA_W-1];
      flags_d.z = ~|result_in;
      flags_d.v = calc_v(sign_a_in, sign_b_in, result_in[DATA_W-1]);
`ifdef MEMSTAGE_CARRY_FLAG_EN
      flags_d.c = carry_in;
`endif
    end
  end

  // Stage FSM: capture, memory wait, and hold under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= EMPTY;
      flags_q       <= '0;
      br_cond_q     <= COND_W'(COND_NV);
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      out_valid     <= 1'b0;
      ctrl_out      <= '0;
      result_out    <= '0;
      br_target_out <= '0;
    end else if (capture) begin
      ctrl_out      <= ctrl_in;
      result_out    <= result_in;
      br_target_out <= br_target_in;
      br_cond_q     <= br_cond_in;
      flags_q       <= flags_d;
      if (is_load | is_store) begin
        state_q   <= MEM;
        out_valid <= 1'b0;
        mem_req   <= 1'b1;
        mem_we    <= is_store;
        mem_addr  <= result_in[ADDR_W-1:0];
        mem_wdata <= store_data_in;
      end else begin
        state_q   <= FULL;
        out_valid <= 1'b1;
      end
    end else begin
      case (state_q)
        MEM: begin
          if (mem_ready) begin
            state_q   <= FULL;
            out_valid <= 1'b1;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            if (!mem_we) result_out <= mem_rdata;
          end
        end
        FULL: begin
          if (out_ready) begin
            state_q   <= EMPTY;
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign flag_n = flags_q.n;
  assign flag_z = flags_q.z;
  assign flag_v = flags_q.v;
`ifdef MEMSTAGE_CARRY_FLAG_EN
  assign flag_c = flags_q.c;
`endif

  kl_cond_eval u_cond_eval (
    .flags  (flags_q),
    .cond   (br_cond_q),
    .take_c (br_take)
  );

endmodule

// File: tb/tb_pipeline_mem_stage.sv
// Bench for pipeline_mem_stage: vector table through a scoreboard plus hand-written corner sequences.
module tb_pipeline_mem_stage;
  import kl_pipe_pkg::*;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 9;
  localparam int unsigned CTRL_W = 22;

  typedef struct {
    logic              ld;
    logic              st;
    logic              sf;
    logic [DATA_W-1:0] res;
    logic [DATA_W-1:0] sd;
    logic              a;
    logic              b;
    logic [3:0]        cond;
    logic [DATA_W-1:0] tgt;
    logic [CTRL_W-1:0] ctrl;
    int                waits;
    logic [DATA_W-1:0] rdata;
    logic [DATA_W-1:0] exp_res;
    logic [2:0]        exp_nzv;
    logic              exp_take;
  } vec_t;

  typedef struct {
    logic [DATA_W-1:0] res;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] tgt;
    logic [2:0]        nzv;
    logic              take;
  } out_t;

  typedef struct {
    int                waits;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
  } resp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [CTRL_W-1:0] ctrl_in = '0;
  logic              is_load = 1'b0;
  logic              is_store = 1'b0;
  logic              set_flags = 1'b0;
  logic [DATA_W-1:0] result_in = '0;
  logic [DATA_W-1:0] store_data_in = '0;
  logic              sign_a_in = 1'b0;
  logic              sign_b_in = 1'b0;
  logic [DATA_W-1:0] br_target_in = '0;
  logic [COND_W-1:0] br_cond_in = '0;
`ifdef MEMSTAGE_CARRY_FLAG_EN
  logic              carry_in = 1'b0;
  logic              flag_c;
`endif
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [CTRL_W-1:0] ctrl_out;
  logic [DATA_W-1:0] result_out;
  logic              flag_n;
  logic              flag_z;
  logic              flag_v;
  logic              br_take;
  logic [DATA_W-1:0] br_target_out;

  logic              resp_ready = 1'b0;
  logic              spur_ready = 1'b0;
  logic [DATA_W-1:0] resp_rdata = '0;

  int n_pass = 0;
  int n_total = 0;

  out_t  exp_q[$];
  resp_t resp_q[$];

  assign mem_ready = resp_ready | spur_ready;
  assign mem_rdata = resp_rdata;

  always #5 clk = ~clk;

  pipeline_mem_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CTRL_W(CTRL_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .ctrl_in       (ctrl_in),
    .is_load       (is_load),
    .is_store      (is_store),
    .set_flags     (set_flags),
    .result_in     (result_in),
    .store_data_in (store_data_in),
    .sign_a_in     (sign_a_in),
    .sign_b_in     (sign_b_in),
    .br_target_in  (br_target_in),
    .br_cond_in    (br_cond_in),
`ifdef MEMSTAGE_CARRY_FLAG_EN
    .carry_in      (carry_in),
    .flag_c        (flag_c),
`endif
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_ready     (mem_ready),
    .mem_rdata     (mem_rdata),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .ctrl_out      (ctrl_out),
    .result_out    (result_out),
    .flag_n        (flag_n),
    .flag_z        (flag_z),
    .flag_v        (flag_v),
    .br_take       (br_take),
    .br_target_out (br_target_out)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic vec_t mk(input int id, input logic ld, input logic st, input logic sf,
                              input logic [15:0] res, input logic [15:0] sd, input logic a,
                              input logic b, input logic [3:0] cond, input int waits,
                              input logic [15:0] rdata, input logic [15:0] exp_res,
                              input logic [2:0] exp_nzv, input logic exp_take);
    vec_t v;
    v.ld = ld; v.st = st; v.sf = sf; v.res = res; v.sd = sd; v.a = a; v.b = b;
    v.cond = cond; v.waits = waits; v.rdata = rdata; v.exp_res = exp_res;
    v.exp_nzv = exp_nzv; v.exp_take = exp_take;
    v.tgt  = 16'hB000 + 16'(id);
    v.ctrl = 22'h2A5000 ^ 22'(id * 37);
    return v;
  endfunction

  // Present one op, wait (bounded) for acceptance, and log what must come out of the stage.
  task automatic drive_op(input vec_t v, output int waited);
    out_t  e;
    resp_t r;
    waited        = 0;
    in_valid      = 1'b1;
    is_load       = v.ld;
    is_store      = v.st;
    set_flags     = v.sf;
    result_in     = v.res;
    store_data_in = v.sd;
    sign_a_in     = v.a;
    sign_b_in     = v.b;
    br_cond_in    = COND_W'(v.cond);
    br_target_in  = v.tgt;
    ctrl_in       = v.ctrl;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
    else begin
      e.res = v.exp_res; e.ctrl = v.ctrl; e.tgt = v.tgt; e.nzv = v.exp_nzv; e.take = v.exp_take;
      exp_q.push_back(e);
      if (v.ld || v.st) begin
        r.waits = v.waits; r.we = v.st; r.addr = v.res[ADDR_W-1:0];
        r.wdata = v.sd; r.rdata = v.rdata;
        resp_q.push_back(r);
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Output scoreboard: every transfer downstream is matched against the oldest accepted op.
  always @(negedge clk) begin
    out_t e;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("out_unexpected", 32'(exp_q.size()), 32'd1);
      else begin
        e = exp_q.pop_front();
        chk("out_result", 32'(result_out), 32'(e.res));
        chk("out_ctrl", 32'(ctrl_out), 32'(e.ctrl));
        chk("out_target", 32'(br_target_out), 32'(e.tgt));
        chk("out_flags_nzv", 32'({flag_n, flag_z, flag_v}), 32'(e.nzv));
        chk("out_br_take", 32'(br_take), 32'(e.take));
      end
    end
  end

  // Memory model: waits the requested cycles, checks the request is held stable, then completes.
  always @(negedge clk) begin
    static resp_t cur;
    static bit    busy = 1'b0;
    static int    cnt = 0;
    if (rst) begin
      busy       = 1'b0;
      resp_ready = 1'b0;
      resp_q.delete();
    end else begin
      resp_ready = 1'b0;
      if (mem_req && !busy) begin
        if (resp_q.size() == 0) chk("mem_unexpected_req", 32'(resp_q.size()), 32'd1);
        else begin
          cur  = resp_q.pop_front();
          busy = 1'b1;
          cnt  = cur.waits;
        end
      end
      if (busy && mem_req) begin
        chk("mem_we", 32'(mem_we), 32'(cur.we));
        chk("mem_addr", 32'(mem_addr), 32'(cur.addr));
        chk("mem_wdata", 32'(mem_wdata), 32'(cur.wdata));
        if (cnt == 0) begin
          resp_ready = 1'b1;
          resp_rdata = cur.rdata;
          busy       = 1'b0;
        end else cnt--;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[12];
    vec_t v;
    int   w;

    //            id ld st sf  res       sd        a  b  cond wt rdata     exp_res   nzv     take
    tbl[0]  = mk(0,  0, 0, 1, 16'h0005, 16'h0000, 0, 0, 4'd6, 0, 16'h0000, 16'h0005, 3'b000, 1);
    tbl[1]  = mk(1,  0, 0, 1, 16'h0000, 16'h0000, 0, 0, 4'd2, 0, 16'h0000, 16'h0000, 3'b010, 1);
    tbl[2]  = mk(2,  0, 0, 0, 16'hFFFF, 16'h0000, 1, 1, 4'd3, 0, 16'h0000, 16'hFFFF, 3'b010, 0);
    tbl[3]  = mk(3,  1, 0, 0, 16'h01A5, 16'h0000, 0, 0, 4'd1, 2, 16'hBEEF, 16'hBEEF, 3'b010, 1);
    tbl[4]  = mk(4,  0, 1, 1, 16'h0123, 16'h5A5A, 0, 0, 4'd5, 1, 16'h0000, 16'h0123, 3'b000, 0);
    tbl[5]  = mk(5,  0, 0, 1, 16'h8000, 16'h0000, 0, 1, 4'd4, 0, 16'h0000, 16'h8000, 3'b101, 0);
    tbl[6]  = mk(6,  0, 0, 1, 16'h0000, 16'h0000, 0, 1, 4'd2, 0, 16'h0000, 16'h0000, 3'b010, 1);
    tbl[7]  = mk(7,  0, 0, 1, 16'h7FFF, 16'h0000, 1, 0, 4'd7, 0, 16'h0000, 16'h7FFF, 3'b001, 0);
    tbl[8]  = mk(8,  1, 0, 1, 16'h0010, 16'h0000, 0, 0, 4'd4, 0, 16'h8001, 16'h8001, 3'b000, 0);
    tbl[9]  = mk(9,  0, 0, 0, 16'h1234, 16'h0000, 0, 0, 4'd0, 0, 16'h0000, 16'h1234, 3'b000, 0);
    tbl[10] = mk(10, 0, 0, 1, 16'hC000, 16'h0000, 1, 1, 4'd4, 0, 16'h0000, 16'hC000, 3'b100, 1);
    tbl[11] = mk(11, 0, 1, 0, 16'hFE23, 16'hA5A5, 0, 0, 4'd7, 0, 16'h0000, 16'hFE23, 3'b100, 0);

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_result", 32'(result_out), 32'd0);
    chk("rst_flags", 32'({flag_n, flag_z, flag_v}), 32'd0);
    chk("rst_br_take", 32'(br_take), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Vector table, issued back to back with the sink always ready.
    for (int i = 0; i < 12; i++) begin
      drive_op(tbl[i], w);
      if (i == 1 || i == 2) chk("alu_stream_no_stall", 32'(w), 32'd0);
    end

    // Load with two wait states: stalled input and three-cycle capture-to-output latency.
    v = mk(20, 1, 0, 0, 16'h01A5, 16'h0000, 0, 0, 4'd0, 2, 16'hBEEF, 16'hBEEF, 3'b100, 0);
    drive_op(v, w);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("load_wait_in_ready", 32'(in_ready), 32'd0);
      chk("load_wait_out_valid", 32'(out_valid), 32'd0);
    end
    @(negedge clk);
    chk("load_out_valid", 32'(out_valid), 32'd1);
    chk("load_result", 32'(result_out), 32'hBEEF);
    wait_drain();

    // Backpressure for four cycles, with a pending op and a stray mem_ready.
    out_ready = 1'b0;
    v = mk(21, 0, 0, 1, 16'h0042, 16'h0000, 0, 0, 4'd7, 0, 16'h0000, 16'h0042, 3'b000, 1);
    drive_op(v, w);
    in_valid   = 1'b1;
    result_in  = 16'h0099;
    ctrl_in    = 22'h012345;
    set_flags  = 1'b0;
    is_load    = 1'b0;
    is_store   = 1'b0;
    spur_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_result_hold", 32'(result_out), 32'h0042);
      chk("bp_ctrl_hold", 32'(ctrl_out), 32'(v.ctrl));
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    spur_ready = 1'b0;
    out_ready  = 1'b1;
    v = mk(22, 0, 0, 0, 16'h0099, 16'h0000, 0, 0, 4'd2, 0, 16'h0000, 16'h0099, 3'b000, 0);
    drive_op(v, w);
    chk("bp_release_no_stall", 32'(w), 32'd0);
    wait_drain();

    // Reset in the middle of a long memory wait abandons the op and clears flags.
    v = mk(23, 1, 0, 1, 16'h8000, 16'h0000, 0, 0, 4'd1, 10, 16'h1111, 16'h1111, 3'b100, 1);
    drive_op(v, w);
    @(negedge clk);
    chk("mid_mem_req", 32'(mem_req), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_hold_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("midrst_mem_req", 32'(mem_req), 32'd0);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_flags", 32'({flag_n, flag_z, flag_v}), 32'd0);
    chk("midrst_br_take", 32'(br_take), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    v = mk(24, 0, 0, 0, 16'h0777, 16'h0000, 0, 0, 4'd1, 0, 16'h0000, 16'h0777, 3'b000, 1);
    drive_op(v, w);
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
